// File: rtl/bus_resp_collector.sv
// rtl/bus_resp_collector.sv - response-return collector for the Timer/PWM/PWM_1 peripheral bus
//
// Tracks the single outstanding bus transaction and returns one registered
// acknowledge or error, plus read data, to the master.
// Optional feature macro: BUS_TIMEOUT_EN (adds a WAIT-state timeout counter).
//
// Ports:
//   iCLK, iRSTn                        clock (rising edge), async active-low reset
//   iSTB                               master strobe, held until oACK/oERR is seen
//   iSTB_Timer/iSTB_PWM/iSTB_PWM_1     decoded per-slave strobes
//   iACK_Timer/iACK_PWM/iACK_PWM_1     slave acknowledges
//   iDAT_Timer/iDAT_PWM/iDAT_PWM_1     slave read data (32 bit)
//   oACK, oERR                         registered one-cycle response pulses
//   oDAT                               registered read data (ERR_DATA on error)
//   oBUSY                              transaction outstanding

module bus_resp_collector #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iSTB,
  input  logic        iSTB_Timer,
  input  logic        iSTB_PWM,
  input  logic        iSTB_PWM_1,
  input  logic        iACK_Timer,
  input  logic        iACK_PWM,
  input  logic        iACK_PWM_1,
  input  logic [31:0] iDAT_Timer,
  input  logic [31:0] iDAT_PWM,
  input  logic [31:0] iDAT_PWM_1,
  output logic        oACK,
  output logic        oERR,
  output logic [31:0] oDAT,
  output logic        oBUSY
);

  generate
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 2..65535");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

  state_t      state, state_nxt;
  logic [2:0]  sel_q, sel_nxt;
  logic [2:0]  strb;
  logic [2:0]  acks;
  logic        one_hot;
  logic        ack_sel;
  logic        expired;
  logic [31:0] dat_sel;

  // Bit order everywhere: {PWM_1, PWM, Timer}
  assign strb    = {iSTB_PWM_1, iSTB_PWM, iSTB_Timer};
  assign acks    = {iACK_PWM_1, iACK_PWM, iACK_Timer};
  assign one_hot = (strb == 3'b001) || (strb == 3'b010) || (strb == 3'b100);
  // Only the latched slave may complete the transaction; stray ACKs vanish here.
  assign ack_sel = |(sel_q & acks);

  always_comb begin
    dat_sel = 32'h0;
    if (sel_q[0]) begin
      dat_sel = iDAT_Timer;
    end else if (sel_q[1]) begin
      dat_sel = iDAT_PWM;
    end else if (sel_q[2]) begin
      dat_sel = iDAT_PWM_1;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Counts WAIT cycles; held at zero outside WAIT so every access starts fresh.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      cnt_q <= '0;
    end else if (state == WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    case (state)
      IDLE: begin
        if (iSTB) begin
          if (one_hot) begin
            sel_nxt   = strb;
            state_nxt = WAIT;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      WAIT: begin
        // Priority: ACK beats both a same-cycle abort and timeout expiry.
        if (ack_sel) begin
          state_nxt = RESP;
        end else if (!iSTB) begin
          state_nxt = IDLE;
        end else if (expired) begin
          state_nxt = ERR;
        end
      end
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= IDLE;
      sel_q <= 3'b000;
      oACK  <= 1'b0;
      oERR  <= 1'b0;
      oDAT  <= 32'h0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
      // Response flops load alongside the state that owns them, so the
      // pulse and its data appear in the RESP/ERR cycle itself.
      oACK  <= (state_nxt == RESP);
      oERR  <= (state_nxt == ERR);
      if (state_nxt == RESP) begin
        oDAT <= dat_sel;
      end else if (state_nxt == ERR) begin
        oDAT <= ERR_DATA;
      end
    end
  end

  assign oBUSY = (state != IDLE);

endmodule

// File: tb/tb_bus_resp_collector.sv
// tb/tb_bus_resp_collector.sv - self-checking bench for bus_resp_collector
module tb_bus_resp_collector;

  localparam int          T   = 4;
  localparam int          LIM = 14;
  localparam logic [31:0] ED  = 32'hDEAD_BEEF;
`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRSTn;
  logic        iSTB;
  logic [2:0]  strb;
  logic [2:0]  acks;
  logic [31:0] iDAT_Timer, iDAT_PWM, iDAT_PWM_1;
  logic        oACK, oERR, oBUSY;
  logic [31:0] oDAT;

  int checks = 0;
  int passed = 0;
  logic [31:0] model_dat;

  always #5 iCLK = ~iCLK;

  bus_resp_collector #(.TIMEOUT_CYCLES(T), .ERR_DATA(ED)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iSTB(iSTB),
    .iSTB_Timer(strb[0]), .iSTB_PWM(strb[1]), .iSTB_PWM_1(strb[2]),
    .iACK_Timer(acks[0]), .iACK_PWM(acks[1]), .iACK_PWM_1(acks[2]),
    .iDAT_Timer(iDAT_Timer), .iDAT_PWM(iDAT_PWM), .iDAT_PWM_1(iDAT_PWM_1),
    .oACK(oACK), .oERR(oERR), .oDAT(oDAT), .oBUSY(oBUSY)
  );

  typedef struct {
    string       name;
    logic [2:0]  sel;
    int          ack_cyc;
    int          abort_cyc;
    logic [2:0]  stray;
    logic [31:0] dt, dp, dp1;
    int          e_nack, e_nerr, e_at, e_idle;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // One master access. WAIT cycle k is the cycle after edge Ek; results are
  // reported as the edge number after which a pulse / idle was observed.
  task automatic run_txn(input vec_t v, output int nack, output int nerr,
                         output int resp_at, output int idle_at);
    bit live;
    iDAT_Timer = v.dt; iDAT_PWM = v.dp; iDAT_PWM_1 = v.dp1;
    iSTB = 1'b1; strb = v.sel; acks = 3'b000;
    nack = 0; nerr = 0; resp_at = -1; idle_at = -1; live = 1'b1;
    for (int k = 0; k < LIM; k++) begin
      @(posedge iCLK); #1;
      if (live) begin
        acks = (k == v.ack_cyc) ? v.sel : 3'b000;
        if (k == 0) acks = acks | (v.stray & ~v.sel);
        if (v.abort_cyc >= 0 && k >= v.abort_cyc) begin
          iSTB = 1'b0; strb = 3'b000;
        end
      end else begin
        acks = 3'b000;
      end
      @(negedge iCLK);
      if (k == 0) chk({v.name, "_busy_e0"}, 32'(oBUSY), 32'd1);
      if (oACK) begin nack++; resp_at = k; end
      if (oERR) begin nerr++; resp_at = k; end
      if (!oBUSY && idle_at < 0) idle_at = k;
      if (oACK || oERR) begin
        live = 1'b0; iSTB = 1'b0; strb = 3'b000; acks = 3'b000;
      end
    end
    iSTB = 1'b0; strb = 3'b000; acks = 3'b000;
    @(posedge iCLK); @(negedge iCLK);
    chk({v.name, "_busy_end"}, 32'(oBUSY), 32'd0);
  endtask

  task automatic apply(input vec_t v);
    int nack, nerr, at, idle;
    run_txn(v, nack, nerr, at, idle);
    chk({v.name, "_nack"}, 32'(nack), 32'(v.e_nack));
    chk({v.name, "_nerr"}, 32'(nerr), 32'(v.e_nerr));
    chk({v.name, "_resp_edge"}, 32'(at), 32'(v.e_at));
    chk({v.name, "_idle_edge"}, 32'(idle), 32'(v.e_idle));
    chk({v.name, "_dat"}, oDAT, v.e_dat);
  endtask

  // Reference: earliest of (selected ACK, abort, timeout) decides, ACK winning ties.
  task automatic model(inout vec_t v);
    int pop, a, b, tm;
    localparam int BIG = 1000;
    pop = int'(v.sel[0]) + int'(v.sel[1]) + int'(v.sel[2]);
    a  = (v.ack_cyc < 0) ? BIG : v.ack_cyc;
    b  = (v.abort_cyc < 0) ? BIG : v.abort_cyc;
    tm = TMO_EN ? T - 1 : BIG;
    v.e_nack = 0; v.e_nerr = 0; v.e_at = -1; v.e_idle = -1; v.e_dat = model_dat;
    if (pop != 1) begin
      v.e_nerr = 1; v.e_at = 0; v.e_idle = 1; v.e_dat = ED;
    end else if (a < BIG && a <= b && a <= tm) begin
      v.e_nack = 1; v.e_at = a + 1; v.e_idle = a + 2;
      v.e_dat = v.sel[0] ? v.dt : (v.sel[1] ? v.dp : v.dp1);
    end else if (b < BIG && b <= tm) begin
      v.e_idle = b + 1;
    end else if (tm < BIG) begin
      v.e_nerr = 1; v.e_at = tm + 1; v.e_idle = tm + 2; v.e_dat = ED;
    end
    model_dat = v.e_dat;
  endtask

  initial begin
    vec_t v;
    int pulses;
    int ack_edge[2];
    logic [31:0] ack_dat[2];
    int na;

    tbl[0] = '{"pwm_read", 3'b010, 2, -1, 3'b000, 32'h0, 32'h0000_1234, 32'h0, 1, 0, 3, 4, 32'h0000_1234};
    tbl[1] = '{"unmapped", 3'b000, -1, -1, 3'b000, 32'h1, 32'h2, 32'h3, 0, 1, 0, 1, ED};
    tbl[2] = '{"ambiguous", 3'b101, 0, -1, 3'b000, 32'h1, 32'h2, 32'h3, 0, 1, 0, 1, ED};
    tbl[3] = '{"stray_ack", 3'b001, 2, -1, 3'b100, 32'h5, 32'h0, 32'hFFFF_FFFF, 1, 0, 3, 4, 32'h5};
    tbl[4] = '{"no_ack", 3'b001, -1, -1, 3'b000, 32'h6, 32'h0, 32'h0,
               0, TMO_EN ? 1 : 0, TMO_EN ? 4 : -1, TMO_EN ? 5 : -1, TMO_EN ? ED : 32'h5};
    tbl[5] = '{"ack_4th_wait", 3'b001, 3, -1, 3'b000, 32'h0000_A5A5, 32'h0, 32'h0, 1, 0, 4, 5, 32'h0000_A5A5};
    tbl[6] = '{"abort", 3'b010, -1, 1, 3'b000, 32'h0, 32'h1357, 32'h0, 0, 0, -1, 2, 32'h0000_A5A5};
    tbl[7] = '{"ack_abort_tie", 3'b100, 1, 1, 3'b000, 32'h0, 32'h0, 32'h77, 1, 0, 2, 3, 32'h77};
    tbl[8] = '{"late_ack", 3'b010, 5, -1, 3'b011, 32'h0, 32'h99, 32'h0,
               TMO_EN ? 0 : 1, TMO_EN ? 1 : 0, TMO_EN ? 4 : 6, TMO_EN ? 5 : 7, TMO_EN ? ED : 32'h99};

    iRSTn = 1'b0; iSTB = 1'b0; strb = 3'b000; acks = 3'b000;
    iDAT_Timer = 32'h0; iDAT_PWM = 32'h0; iDAT_PWM_1 = 32'h0;
    @(negedge iCLK); @(negedge iCLK);
    chk("reset_ack", 32'(oACK), 32'd0);
    chk("reset_err", 32'(oERR), 32'd0);
    chk("reset_busy", 32'(oBUSY), 32'd0);
    chk("reset_dat", oDAT, 32'h0);
    iRSTn = 1'b1;
    @(negedge iCLK);

    for (int i = 0; i < 9; i++) apply(tbl[i]);

    model_dat = tbl[8].e_dat;
    for (int i = 0; i < 30; i++) begin
      int r;
      r = int'($urandom_range(0, 3));
      v.name = $sformatf("rnd%0d", i);
      v.sel = (r < 3) ? 3'(3'b001 << r) : 3'($urandom_range(0, 7));
      v.ack_cyc = int'($urandom_range(0, 9)) - 1;
      v.abort_cyc = int'($urandom_range(0, 9)) - 1;
      v.stray = 3'($urandom_range(0, 7));
      v.dt = $urandom; v.dp = $urandom; v.dp1 = $urandom;
      model(v);
      apply(v);
    end

    // Reset in the middle of WAIT: outputs clear at once, nothing after release.
    iSTB = 1'b1; strb = 3'b001; iDAT_Timer = 32'h4242;
    @(posedge iCLK); @(negedge iCLK);
    @(posedge iCLK); @(negedge iCLK);
    chk("rst_mid_busy_before", 32'(oBUSY), 32'd1);
    #2 iRSTn = 1'b0; acks = 3'b001;
    #1;
    chk("rst_mid_busy", 32'(oBUSY), 32'd0);
    chk("rst_mid_ack", 32'(oACK), 32'd0);
    chk("rst_mid_err", 32'(oERR), 32'd0);
    chk("rst_mid_dat", oDAT, 32'h0);
    @(negedge iCLK);
    iSTB = 1'b0; strb = 3'b000; acks = 3'b000;
    iRSTn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge iCLK);
      if (oACK || oERR || oBUSY) pulses++;
    end
    chk("rst_mid_no_pulse", 32'(pulses), 32'd0);

    // Back-to-back with iSTB held: Timer then PWM, each ACKing in the first WAIT cycle.
    iDAT_Timer = 32'h1111_0001; iDAT_PWM = 32'h2222_0002;
    iSTB = 1'b1; strb = 3'b001; na = 0;
    ack_edge[0] = -1; ack_edge[1] = -1; ack_dat[0] = 32'h0; ack_dat[1] = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(posedge iCLK); #1;
      acks = {1'b0, (k == 3), (k == 0)};
      if (k == 1) strb = 3'b010;
      @(negedge iCLK);
      if (oACK && na < 2) begin
        ack_edge[na] = k; ack_dat[na] = oDAT; na++;
        if (na == 2) begin iSTB = 1'b0; strb = 3'b000; end
      end
    end
    iSTB = 1'b0; strb = 3'b000; acks = 3'b000;
    chk("b2b_count", 32'(na), 32'd2);
    chk("b2b_edge0", 32'(ack_edge[0]), 32'd1);
    chk("b2b_edge1", 32'(ack_edge[1]), 32'd4);
    chk("b2b_dat0", ack_dat[0], 32'h1111_0001);
    chk("b2b_dat1", ack_dat[1], 32'h2222_0002);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // oACK and oERR must never coincide.
  always @(negedge iCLK) begin
    if (iRSTn && oACK && oERR) chk("ack_err_overlap", 32'd1, 32'd0);
  end

endmodule
